id_ex_pipe_stage: RTL

Parametrised ID/EX pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and a bubble counter. It sits between the decode stage (upstream producer) and the execute stage (downstream consumer). It replaces the fixed-width, always-load ID/EX latch. Stalls and flushes no longer drop or duplicate instructions, and any bubble reaches EX with all control bits forced to zero.

---
 rtl/id_ex_pipe_stage.sv | 108 ++++++++++
 1 files changed

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register: valid/ready handshake, main + skid entry, synchronous flush
// and a saturating count of cycles in which the stage holds nothing.
module id_ex_pipe_stage #(
  parameter int CTRL_W = 11,
  parameter int DATA_W = 106,
  parameter int BUB_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              bub_clr,
  output logic [BUB_W-1:0]  bub_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready on that side.
  // in_ready and out_valid come from the registered state only.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q;
  logic [CTRL_W-1:0]  main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0]  main_data_q, skid_data_q;
  logic [BUB_W-1:0]   bub_q, bub_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (flush) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (out_ready && in_valid) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
          end else if (out_ready) begin
            state_q <= EMPTY;
          end else if (in_valid) begin
            skid_ctrl_q <= in_ctrl;
            skid_data_q <= in_data;
            state_q     <= FULL;
          end
        end
        FULL: begin
          // in_ready is low here, so in_valid cannot be a transfer.
          if (out_ready) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            state_q     <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  always_comb begin
    bub_d = bub_q;
    if (bub_clr) begin
      bub_d = '0;
    end else if ((state_q == EMPTY) && (bub_q != {BUB_W{1'b1}})) begin
      bub_d = bub_q + BUB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bub_q <= '0;
    end else begin
      bub_q <= bub_d;
    end
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
  assign out_data  = main_data_q & {DATA_W{out_valid}};
  assign bub_cnt   = bub_q;
  assign dbg_state = state_q;

endmodule
